// File: rtl/axo_peri_gpio_irq_if.sv
// Register-access bus between a host and a peripheral: word address, 32-bit data,
// with a ready/rdata return path.
interface axo_peri_bus;
    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport MEM (input re, we, addr, wdata, output ready, rdata);
    modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/axo_peri_gpio_irq.sv
// GPIO block with set/clear/toggle output control, synchronized inputs and
// latched rise/fall edge status that drives a level interrupt.
module axo_peri_gpio_irq #(
    parameter int num_pins    = 32,
    parameter int sync_stages = 2
) (
    input  logic                clk,
    input  logic                rst,
    axo_peri_bus.MEM            bus,
    output logic [num_pins-1:0] iolevel,
    output logic [num_pins-1:0] iodir,
    input  logic [num_pins-1:0] sense,
    output logic                irq
);

    typedef logic [num_pins-1:0] pins_t;

    localparam logic [7:0] ADDR_DIR     = 8'd0;
    localparam logic [7:0] ADDR_OUT     = 8'd1;
    localparam logic [7:0] ADDR_IN      = 8'd2;
    localparam logic [7:0] ADDR_OUT_SET = 8'd3;
    localparam logic [7:0] ADDR_OUT_CLR = 8'd4;
    localparam logic [7:0] ADDR_OUT_TGL = 8'd5;
    localparam logic [7:0] ADDR_IE      = 8'd6;
    localparam logic [7:0] ADDR_RISE_EN = 8'd7;
    localparam logic [7:0] ADDR_FALL_EN = 8'd8;
    localparam logic [7:0] ADDR_STATUS  = 8'd9;

    pins_t dir_q, dir_d;
    pins_t out_q, out_d;
    pins_t ie_q, ie_d;
    pins_t rise_en_q, rise_en_d;
    pins_t fall_en_q, fall_en_d;
    pins_t status_q, status_d;
    pins_t prev_q;
    pins_t sync_q [sync_stages];
    pins_t in_w, wmask, clr, rise, fall, rd;

    assign wmask = bus.wdata[num_pins-1:0];
    assign in_w  = sync_q[sync_stages-1];
    assign rise  = in_w & ~prev_q & rise_en_q;
    assign fall  = ~in_w & prev_q & fall_en_q;

    assign bus.ready = 1'b1;
    assign iodir     = dir_q;
    assign iolevel   = out_q;
    assign irq       = |(status_q & ie_q);

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        ie_d      = ie_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (bus.we) begin
            case (bus.addr)
                ADDR_DIR:     dir_d     = wmask;
                ADDR_OUT:     out_d     = wmask;
                ADDR_OUT_SET: out_d     = out_q | wmask;
                ADDR_OUT_CLR: out_d     = out_q & ~wmask;
                ADDR_OUT_TGL: out_d     = out_q ^ wmask;
                ADDR_IE:      ie_d      = wmask;
                ADDR_RISE_EN: rise_en_d = wmask;
                ADDR_FALL_EN: fall_en_d = wmask;
                ADDR_STATUS:  clr       = wmask;
                default:      ;
            endcase
        end
        // A fresh edge is OR-ed in after the clear so it survives a same-cycle w1c.
        status_d = (status_q & ~clr) | rise | fall;
    end

    always_comb begin
        rd = '0;
        case (bus.addr)
            ADDR_DIR:     rd = dir_q;
            ADDR_OUT:     rd = out_q;
            ADDR_IN:      rd = in_w;
            ADDR_IE:      rd = ie_q;
            ADDR_RISE_EN: rd = rise_en_q;
            ADDR_FALL_EN: rd = fall_en_q;
            ADDR_STATUS:  rd = status_q;
            default:      rd = '0;
        endcase
        bus.rdata               = '0;
        bus.rdata[num_pins-1:0] = rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            ie_q      <= ie_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= in_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sense;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

endmodule

// File: doc/axo_peri_gpio_irq.md
AXO_PERI_GPIO_IRQ -- requirements
Module: axo_peri_gpio_irq

Interface
REQ-001 SHALL have parameter num_pins, default 32, number of I/O pins (1..32).
REQ-002 SHALL have parameter sync_stages, default 2, input synchronizer depth (>=1).
REQ-003 SHALL have port clk  input  1  peripheral bus clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port bus  axo_peri_bus.MEM  re/we/addr(word index)/wdata 32/ready/rdata 32  register access.
REQ-006 SHALL have port iolevel  output  num_pins  pin output levels.
REQ-007 SHALL have port iodir  output  num_pins  pin output enables (1 = drive).
REQ-008 SHALL have port sense  input  num_pins  asynchronous pad levels.
REQ-009 SHALL have port irq  output  1  level interrupt request.

Function
REQ-010 SHALL hold bus.ready at 1; every access completes in the cycle presented.
REQ-011 SHALL drive bus.rdata combinationally from bus.addr; reads have no side effects.
REQ-012 SHALL decode word addresses: 0 DIR rw, 1 OUT rw, 2 IN ro, 3 OUT_SET wo, 4 OUT_CLR wo, 5 OUT_TGL wo, 6 IE rw, 7 RISE_EN rw, 8 FALL_EN rw, 9 STATUS r/w1c.
REQ-013 SHALL read 0 from wo registers and from unmapped addresses; writes to them (and to IN) SHALL be ignored.
REQ-014 SHALL read 0 in rdata bits [31:num_pins]; wdata bits above num_pins ignored.
REQ-015 SHALL apply writes on the clk edge where bus.we=1; new value visible on rdata the next cycle.
REQ-016 OUT_SET/OUT_CLR/OUT_TGL SHALL set/clear/invert OUT bits where wdata=1; other bits unchanged.
REQ-017 SHALL drive iodir from DIR and iolevel from OUT directly (registered, no extra delay).
REQ-018 SHALL pass each sense bit through a sync_stages-deep flop chain; IN = last stage.
REQ-019 SHALL register previous IN (prev); rise = IN & ~prev & RISE_EN, fall = ~IN & prev & FALL_EN.
REQ-020 SHALL set STATUS bits on the edge after the edge at which IN changes; STATUS latches until cleared.
REQ-021 Pad change sampled at edge k SHALL appear on IN after edge k+sync_stages-1 and in STATUS after edge k+sync_stages.
REQ-022 STATUS write SHALL clear bits where wdata=1; simultaneous new edge on the same bit SHALL win (bit stays 1).
REQ-023 Edge detection SHALL operate regardless of DIR (driven pins loop back through sense).
REQ-024 SHALL drive irq = |(STATUS & IE), combinational from registers, no pipeline delay.
REQ-025 Clearing RISE_EN/FALL_EN SHALL NOT clear already-latched STATUS bits.
REQ-026 re without we SHALL change no state; we with re SHALL behave as a write.

Reset
REQ-027 On rst=1 at clk edge: DIR, OUT, IE, RISE_EN, FALL_EN, STATUS, sync chain, prev SHALL become 0.
REQ-028 During and after reset: iodir=0, iolevel=0, irq=0; rst SHALL override any same-cycle bus write.
REQ-029 A pin high through reset SHALL NOT produce a rise event after RISE_EN is later set, unless it falls and rises again.

Verification
REQ-030 Write DIR=0x0000FFFF, OUT=0xA5A5A5A5 -> iodir=0x0000FFFF, iolevel=0xA5A5A5A5; read addr 0 returns 0x0000FFFF.
REQ-031 OUT=0x0F; write OUT_SET=0xF0, OUT_CLR=0x03, OUT_TGL=0x101 -> OUT reads 0xFF, 0xFC, 0x1FD.
REQ-032 sync_stages=2, RISE_EN=IE=0x1, sense[0] 0->1 sampled at edge k -> IN[0]=1 after k+1, STATUS=0x1 and irq=1 after k+2.
REQ-033 STATUS=0x1; write STATUS=0x1 in same cycle a new rise on bit 0 is detected -> STATUS stays 0x1, irq stays 1.
REQ-034 FALL_EN=0x2, IE=0: pin 1 falls -> STATUS=0x2, irq=0; write IE=0x2 -> irq=1 next cycle; write STATUS=0x2 -> irq=0.
REQ-035 num_pins=8: write 0xFFFFFFFF to DIR -> reads 0x000000FF; read addr 10 -> 0; assert rst mid-operation -> all registers 0, irq=0.
